update_knn20_udiv_seq: RTL and testbench
========================================

Name: update_knn20_udiv_seq

Overview:
- Sequential unsigned restoring divider, the inverse of the update_knn20 pipelined multiplier.
- Takes a 32-bit product-domain value and a 15-bit divisor.
- Recovers a 17-bit quotient plus remainder, one quotient bit per clock-enabled cycle.
- Used by update_knn20 distance/score normalisation; start/done handshake with HLS-style ce stall.

Parameters:
- DIVIDEND_WIDTH, 32, width of din0 (dividend).
- DIVISOR_WIDTH, 15, width of din1 (divisor) and of rem.
- QUOTIENT_WIDTH, 17, width of dout (quotient); must be <= DIVIDEND_WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; state advances only when ce=1.
- start  in  1  request; sampled only when ce=1 and state IDLE.
- din0  in  DIVIDEND_WIDTH  dividend, captured at accepted start.
- din1  in  DIVISOR_WIDTH  divisor, captured at accepted start.
- busy  out  1  high in CALC/ROUND/DONE states.
- done  out  1  one ce-cycle pulse; results valid.
- dout  out  QUOTIENT_WIDTH  quotient, saturated.
- rem  out  DIVISOR_WIDTH  remainder.
- ovf  out  1  full quotient exceeded QUOTIENT_WIDTH bits.
- dz  out  1  divide by zero.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE.
  - busy=0, done=0, dout=0, rem=0, ovf=0, dz=0.
  - Partial work is discarded.
- IDLE: start=1 with ce=1 captures din0/din1, clears the iteration counter and partial remainder, and moves to CALC. busy=1 from the next edge.
- CALC, each ce=1 cycle:
  - Shift partial remainder (DIVISOR_WIDTH+1 bits) left, bringing in the next dividend MSB.
  - If partial >= divisor: subtract it and set the quotient bit to 1; else the bit is 0.
  - Runs exactly DIVIDEND_WIDTH iterations, with the internal quotient held at full DIVIDEND_WIDTH bits.
  - After the last iteration go to DONE (or ROUND, see Optional Feature).
- DONE: done=1 for exactly one ce=1 cycle, then IDLE.
- Output registers:
  - dout/rem/ovf/dz are written on entry to DONE.
  - They hold until the next accepted start completes, or until reset.
- Latency: done asserts on the (DIVIDEND_WIDTH+1)th ce=1 edge after the accepting edge, i.e. 33 cycles at defaults with ce held high. Latency is fixed, regardless of operand values.
- ce=0 freezes all state and outputs, including a pending done pulse (done stays high while ce=0 in DONE).
- start while busy is ignored; it is not queued.
- Overflow: if full quotient bits above QUOTIENT_WIDTH are nonzero, then dout = all ones and ovf=1; rem stays the true remainder.
- Divide by zero (din1=0):
  - Same fixed latency.
  - dout = all ones, rem = din0[DIVISOR_WIDTH-1:0], dz=1, ovf=0.
- Arithmetic invariant when ovf=0 and dz=0: dout*din1 + rem == din0, with rem < din1.

Optional Feature:
- Macro UPDATE_KNN20_UDIV_ROUND_EN.
- When defined:
  - Extra ROUND state after CALC costs one ce cycle (latency DIVIDEND_WIDTH+2).
  - If 2*rem >= divisor, quotient increments (round half up).
  - rem output is the pre-rounding remainder.
  - An increment that overflows QUOTIENT_WIDTH saturates and sets ovf.
  - dz path bypasses rounding.
- When undefined: truncating quotient, no ROUND state, latency DIVIDEND_WIDTH+1.

Test Plan:
- din0=15, din1=3, ce=1, single start -> done at cycle 33; dout=5, rem=0, ovf=0, dz=0; busy high cycles 1-33.
- din0=4294803457, din1=32767 -> dout=131071 (0x1FFFF), rem=0, ovf=0. Also din0=7, din1=2 -> dout=3, rem=1 (dout=4 with UPDATE_KNN20_UDIV_ROUND_EN, at cycle 34).
- din0=0xFFFFFFFF, din1=1 -> dout=0x1FFFF, ovf=1, rem=0. Also din0=100, din1=0 -> dout=0x1FFFF, rem=100, dz=1, latency 33.
- ce deasserted for 10 cycles mid-CALC, plus a second start pulsed while busy -> done at cycle 43; second start ignored; results match the first operands.
- Assert reset at cycle 12 of an operation -> all outputs 0 immediately (async), state IDLE; a new start after release completes normally in 33 cycles.

Source files
------------

// File: rtl/update_knn20_udiv_seq_if.sv
// Handshake and data bundle for update_knn20_udiv_seq.
// Signals:
//   ce, start  - clock enable and request (master -> slave)
//   din0, din1 - dividend and divisor (master -> slave)
//   busy, done - status; done pulses for one ce cycle when results are valid
//   dout, rem  - saturated quotient and remainder
//   ovf, dz    - quotient overflow and divide-by-zero flags
interface update_knn20_udiv_seq_if #(
    parameter int unsigned DIVIDEND_WIDTH = 32,
    parameter int unsigned DIVISOR_WIDTH  = 15,
    parameter int unsigned QUOTIENT_WIDTH = 17
);
    logic                      ce;
    logic                      start;
    logic [DIVIDEND_WIDTH-1:0] din0;
    logic [DIVISOR_WIDTH-1:0]  din1;
    logic                      busy;
    logic                      done;
    logic [QUOTIENT_WIDTH-1:0] dout;
    logic [DIVISOR_WIDTH-1:0]  rem;
    logic                      ovf;
    logic                      dz;

    modport master (
        output ce, start, din0, din1,
        input  busy, done, dout, rem, ovf, dz
    );

    modport slave (
        input  ce, start, din0, din1,
        output busy, done, dout, rem, ovf, dz
    );
endinterface

// File: rtl/update_knn20_udiv_seq.sv
// Sequential unsigned restoring divider: one quotient bit per ce=1 cycle.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - update_knn20_udiv_seq_if slave modport (ce/start/din0/din1 in,
//          busy/done/dout/rem/ovf/dz out)
// Optional feature: define UPDATE_KNN20_UDIV_ROUND_EN to add a ROUND state
// (round-half-up quotient, one extra ce cycle of latency).
module update_knn20_udiv_seq #(
    parameter int unsigned DIVIDEND_WIDTH = 32,
    parameter int unsigned DIVISOR_WIDTH  = 15,
    parameter int unsigned QUOTIENT_WIDTH = 17
) (
    input logic                    clk,
    input logic                    rst,
    update_knn20_udiv_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(DIVIDEND_WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(DIVIDEND_WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCalc  = 2'd1,
        StRound = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e                      state_q, state_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [DIVIDEND_WIDTH-1:0]   dividend_q, dividend_d;
    logic [DIVISOR_WIDTH-1:0]    divisor_q, divisor_d;
    logic [DIVIDEND_WIDTH-1:0]   quot_q, quot_d;
    logic [DIVISOR_WIDTH:0]      part_q, part_d;
    logic [QUOTIENT_WIDTH-1:0]   dout_q, dout_d;
    logic [DIVISOR_WIDTH-1:0]    rem_q, rem_d;
    logic                        ovf_q, ovf_d;
    logic                        dz_q, dz_d;

    logic [DIVISOR_WIDTH:0]      shifted;
    logic                        ge;
    logic [DIVISOR_WIDTH:0]      part_nx;
    logic [DIVIDEND_WIDTH-1:0]   quot_nx;
    logic [DIVIDEND_WIDTH-1:0]   fin_quot;
    logic [DIVISOR_WIDTH:0]      fin_part;
    logic                        round_up;
    logic [DIVIDEND_WIDTH:0]     quot_rnd;
    logic                        sat;
    logic                        load_out;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        part_d     = part_q;
        dout_d     = dout_q;
        rem_d      = rem_q;
        ovf_d      = ovf_q;
        dz_d       = dz_q;
        load_out   = 1'b0;

        // One restoring step; the partial remainder is always < divisor, so
        // the shifted value never needs more than DIVISOR_WIDTH+1 bits.
        shifted = {part_q[DIVISOR_WIDTH-1:0], dividend_q[LastCnt - cnt_q]};
        ge      = (shifted >= {1'b0, divisor_q});
        part_nx = ge ? (shifted - {1'b0, divisor_q}) : shifted;
        quot_nx = {quot_q[DIVIDEND_WIDTH-2:0], ge};

`ifdef UPDATE_KNN20_UDIV_ROUND_EN
        fin_quot = quot_q;
        fin_part = part_q;
        round_up = ({part_q, 1'b0} >= {2'b00, divisor_q});
`else
        fin_quot = quot_nx;
        fin_part = part_nx;
        round_up = 1'b0;
`endif
        // Extra top bit catches a rounding carry out of the full quotient.
        quot_rnd = {1'b0, fin_quot} + (DIVIDEND_WIDTH + 1)'(round_up);
        sat      = |(quot_rnd >> QUOTIENT_WIDTH);

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    dividend_d = bus.din0;
                    divisor_d  = bus.din1;
                    cnt_d      = '0;
                    part_d     = '0;
                    quot_d     = '0;
                    state_d    = StCalc;
                end
            end
            StCalc: begin
                part_d = part_nx;
                quot_d = quot_nx;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
`ifdef UPDATE_KNN20_UDIV_ROUND_EN
                    state_d = StRound;
`else
                    state_d  = StDone;
                    load_out = 1'b1;
`endif
                end
            end
            StRound: begin
                state_d  = StDone;
                load_out = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (load_out) begin
            if (divisor_q == '0) begin
                dout_d = '1;
                rem_d  = dividend_q[DIVISOR_WIDTH-1:0];
                ovf_d  = 1'b0;
                dz_d   = 1'b1;
            end else begin
                dout_d = sat ? '1 : quot_rnd[QUOTIENT_WIDTH-1:0];
                rem_d  = fin_part[DIVISOR_WIDTH-1:0];
                ovf_d  = sat;
                dz_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            part_q     <= '0;
            dout_q     <= '0;
            rem_q      <= '0;
            ovf_q      <= 1'b0;
            dz_q       <= 1'b0;
        end else if (bus.ce) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            part_q     <= part_d;
            dout_q     <= dout_d;
            rem_q      <= rem_d;
            ovf_q      <= ovf_d;
            dz_q       <= dz_d;
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StDone);
    assign bus.dout = dout_q;
    assign bus.rem  = rem_q;
    assign bus.ovf  = ovf_q;
    assign bus.dz   = dz_q;
endmodule

// File: tb/tb_update_knn20_udiv_seq.sv
// Directed self-checking bench for update_knn20_udiv_seq.
module tb_update_knn20_udiv_seq;
`ifdef UPDATE_KNN20_UDIV_ROUND_EN
    localparam int LAT = 34;
    localparam int Q72 = 4;
    localparam int Q1000_7 = 143;
`else
    localparam int LAT = 33;
    localparam int Q72 = 3;
    localparam int Q1000_7 = 142;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    update_knn20_udiv_seq_if #(
        .DIVIDEND_WIDTH(32),
        .DIVISOR_WIDTH (15),
        .QUOTIENT_WIDTH(17)
    ) bus ();

    update_knn20_udiv_seq #(
        .DIVIDEND_WIDTH(32),
        .DIVISOR_WIDTH (15),
        .QUOTIENT_WIDTH(17)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one start at a negedge and counts posedges until done (bounded).
    task automatic run_op(input logic [31:0] a, input logic [14:0] b, output int lat);
        bus.din0  = a;
        bus.din1  = b;
        bus.start = 1'b1;
        @(negedge clk);
        lat = 1;
        bus.start = 1'b0;
        while (!bus.done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ce = 1'b1;
        bus.start = 1'b0;
        bus.din0 = '0;
        bus.din1 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        n_checks++;
        if (bus.dout !== 17'd0 || bus.rem !== 15'd0 || bus.ovf !== 1'b0 || bus.dz !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: dout=%0d rem=%0d ovf=%b dz=%b expected all 0",
                     bus.dout, bus.rem, bus.ovf, bus.dz);
        end
    endtask

    task automatic test_basic();
        int cyc;
        bus.din0 = 32'd15;
        bus.din1 = 15'd3;
        bus.start = 1'b1;
        for (cyc = 1; cyc <= LAT; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            n_checks++;
            if (bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_busy: cycle %0d busy=%b expected 1", cyc, bus.busy);
            end
            n_checks++;
            if (bus.done !== (cyc == LAT)) begin
                n_fail++;
                $display("FAIL basic_done: cycle %0d done=%b expected %b", cyc, bus.done,
                         cyc == LAT);
            end
        end
        n_checks++;
        if (bus.dout !== 17'd5 || bus.rem !== 15'd0 || bus.ovf !== 1'b0 || bus.dz !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: dout=%0d rem=%0d ovf=%b dz=%b expected 5 0 0 0",
                     bus.dout, bus.rem, bus.ovf, bus.dz);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.dout !== 17'd5) begin
            n_fail++;
            $display("FAIL basic_after: done=%b busy=%b dout=%0d expected 0 0 5",
                     bus.done, bus.busy, bus.dout);
        end
    endtask

    task automatic test_max_quotient();
        int lat;
        run_op(32'd4294803457, 15'd32767, lat);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL max_latency: got %0d expected %0d", lat, LAT);
        end
        n_checks++;
        if (bus.dout !== 17'h1FFFF || bus.rem !== 15'd0 || bus.ovf !== 1'b0 || bus.dz !== 1'b0) begin
            n_fail++;
            $display("FAIL max_result: dout=%0h rem=%0d ovf=%b dz=%b expected 1ffff 0 0 0",
                     bus.dout, bus.rem, bus.ovf, bus.dz);
        end
        @(negedge clk);
        run_op(32'd7, 15'd2, lat);
        n_checks++;
        if (lat !== LAT || bus.dout !== 17'(Q72) || bus.rem !== 15'd1) begin
            n_fail++;
            $display("FAIL div_7_2: lat=%0d dout=%0d rem=%0d expected %0d %0d 1",
                     lat, bus.dout, bus.rem, LAT, Q72);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow_dz();
        int lat;
        run_op(32'hFFFFFFFF, 15'd1, lat);
        n_checks++;
        if (lat !== LAT || bus.dout !== 17'h1FFFF || bus.rem !== 15'd0 || bus.ovf !== 1'b1 ||
            bus.dz !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow: lat=%0d dout=%0h rem=%0d ovf=%b dz=%b expected %0d 1ffff 0 1 0",
                     lat, bus.dout, bus.rem, bus.ovf, bus.dz, LAT);
        end
        @(negedge clk);
        run_op(32'd100, 15'd0, lat);
        n_checks++;
        if (lat !== LAT || bus.dout !== 17'h1FFFF || bus.rem !== 15'd100 || bus.ovf !== 1'b0 ||
            bus.dz !== 1'b1) begin
            n_fail++;
            $display("FAIL div_zero: lat=%0d dout=%0h rem=%0d ovf=%b dz=%b expected %0d 1ffff 100 0 1",
                     lat, bus.dout, bus.rem, bus.ovf, bus.dz, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_ce_stall();
        int c;
        bus.din0 = 32'd1000;
        bus.din1 = 15'd7;
        bus.start = 1'b1;
        @(negedge clk);
        c = 1;
        bus.start = 1'b0;
        while (!bus.done && c < 200) begin
            if (c == 5) begin
                bus.start = 1'b1;
                bus.din0 = 32'd50;
                bus.din1 = 15'd5;
            end
            if (c == 6) bus.start = 1'b0;
            if (c == 10) bus.ce = 1'b0;
            if (c == 20) bus.ce = 1'b1;
            @(negedge clk);
            c++;
        end
        bus.ce = 1'b1;
        bus.start = 1'b0;
        n_checks++;
        if (c !== LAT + 10) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d expected %0d", c, LAT + 10);
        end
        n_checks++;
        if (bus.dout !== 17'(Q1000_7) || bus.rem !== 15'd6) begin
            n_fail++;
            $display("FAIL stall_result: dout=%0d rem=%0d expected %0d 6", bus.dout, bus.rem, Q1000_7);
        end
        bus.ce = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done_hold: done=%b expected 1", bus.done);
        end
        bus.ce = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_done_drop: done=%b busy=%b expected 0 0", bus.done, bus.busy);
        end
        // The ignored start must not have launched a second operation.
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.dout !== 17'(Q1000_7)) begin
            n_fail++;
            $display("FAIL stall_no_queue: busy=%b dout=%0d expected 0 %0d", bus.busy, bus.dout,
                     Q1000_7);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        bus.din0 = 32'd1000;
        bus.din1 = 15'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dout !== 17'd0 || bus.rem !== 15'd0 ||
            bus.ovf !== 1'b0 || bus.dz !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b done=%b dout=%0d rem=%0d ovf=%b dz=%b expected all 0",
                     bus.busy, bus.done, bus.dout, bus.rem, bus.ovf, bus.dz);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(32'd15, 15'd3, lat);
        n_checks++;
        if (lat !== LAT || bus.dout !== 17'd5 || bus.rem !== 15'd0) begin
            n_fail++;
            $display("FAIL after_reset_op: lat=%0d dout=%0d rem=%0d expected %0d 5 0",
                     lat, bus.dout, bus.rem, LAT);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_max_quotient();
        test_overflow_dz();
        test_ce_stall();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
